// File: rtl/pin_sequencer_pkg.sv
// Shared constants and types for the per-pin sequencer.
package pin_sequencer_pkg;

  // Register offsets relative to the instance base address
  localparam int unsigned OFF_LOCAL_CMD  = 1;
  localparam int unsigned OFF_DUTY       = 2;
  localparam int unsigned OFF_ANTI       = 3;
  localparam int unsigned OFF_CYCLES     = 4;
  localparam int unsigned OFF_SAMPLE_DIV = 5;
  localparam int unsigned OFF_SAMPLE     = 6;
  localparam int unsigned OFF_STATUS     = 7;

  // Broadcast command codes written to absolute address 0
  localparam int unsigned CMD_START = 1;
  localparam int unsigned CMD_STOP  = 2;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_CONST  = 2'd1,
    MODE_PWM    = 2'd2,
    MODE_SAMPLE = 2'd3
  } mode_e;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_CONST  = 5'b00010,
    ST_HIGH   = 5'b00100,
    ST_LOW    = 5'b01000,
    ST_SAMPLE = 5'b10000
  } state_e;

endpackage

// File: rtl/pin_sync2.sv
// Two-flop synchroniser for the asynchronous pin input.
module pin_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the input into the clk domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pin_sequencer.sv
// Per-pin controller: constant drive, PWM trains, or input sampling.
module pin_sequencer
  import pin_sequencer_pkg::*;
#(
  parameter int unsigned POSITION   = 0,
  parameter int unsigned ADDR_WIDTH = 21,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  pin_in,
  output logic                  pin_out,
  output logic                  pin_oe,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned SHW = $clog2(DATA_WIDTH + 1);

  localparam logic [ADDR_WIDTH-1:0] A_LCMD   = ADDR_WIDTH'(POSITION + OFF_LOCAL_CMD);
  localparam logic [ADDR_WIDTH-1:0] A_DUTY   = ADDR_WIDTH'(POSITION + OFF_DUTY);
  localparam logic [ADDR_WIDTH-1:0] A_ANTI   = ADDR_WIDTH'(POSITION + OFF_ANTI);
  localparam logic [ADDR_WIDTH-1:0] A_CYCLES = ADDR_WIDTH'(POSITION + OFF_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] A_SDIV   = ADDR_WIDTH'(POSITION + OFF_SAMPLE_DIV);
  localparam logic [ADDR_WIDTH-1:0] A_SAMPLE = ADDR_WIDTH'(POSITION + OFF_SAMPLE);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(POSITION + OFF_STATUS);

  // Programmable registers
  logic [3:0]           local_cmd;
  logic [CNT_WIDTH-1:0] duty, anti, cycles, sample_div;

  // Sequencer state and its next values
  state_e               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [CNT_WIDTH-1:0] per, per_nxt;
  logic [CNT_WIDTH-1:0] div_cnt, div_nxt;
  logic [SHW-1:0]       shifts, shifts_nxt;
  logic [DATA_WIDTH-1:0] sample, sample_nxt;
  logic                 sample_full, full_nxt;
  logic                 inf, inf_nxt;
  logic                 done_nxt;

  logic pin_s;
  logic glob_wr, start, stop;

  assign glob_wr = we && (addr == '0);
  assign start   = glob_wr && (data_in == DATA_WIDTH'(CMD_START));
  assign stop    = glob_wr && (data_in == DATA_WIDTH'(CMD_STOP));

  // Phase length max(v,1) expressed as a down-count terminal value
  function automatic logic [CNT_WIDTH-1:0] load_val(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  pin_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pin_in),
    .q     (pin_s)
  );

  // Bus-writable registers; read-only offsets and foreign windows are ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      local_cmd  <= '0;
      duty       <= '0;
      anti       <= '0;
      cycles     <= '0;
      sample_div <= '0;
    end else if (we) begin
      if (addr == A_LCMD)   local_cmd  <= data_in[3:0];
      if (addr == A_DUTY)   duty       <= data_in[CNT_WIDTH-1:0];
      if (addr == A_ANTI)   anti       <= data_in[CNT_WIDTH-1:0];
      if (addr == A_CYCLES) cycles     <= data_in[CNT_WIDTH-1:0];
      if (addr == A_SDIV)   sample_div <= data_in[CNT_WIDTH-1:0];
    end
  end

  // Registered read mux, one cycle of latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
    end else begin
      case (addr)
        A_LCMD:   data_out <= DATA_WIDTH'(local_cmd);
        A_DUTY:   data_out <= DATA_WIDTH'(duty);
        A_ANTI:   data_out <= DATA_WIDTH'(anti);
        A_CYCLES: data_out <= DATA_WIDTH'(cycles);
        A_SDIV:   data_out <= DATA_WIDTH'(sample_div);
        A_SAMPLE: data_out <= sample;
        A_STATUS: data_out <= DATA_WIDTH'({sample_full, busy});
        default:  data_out <= '0;
      endcase
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      per         <= '0;
      div_cnt     <= '0;
      shifts      <= '0;
      sample      <= '0;
      sample_full <= 1'b0;
      inf         <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      per         <= per_nxt;
      div_cnt     <= div_nxt;
      shifts      <= shifts_nxt;
      sample      <= sample_nxt;
      sample_full <= full_nxt;
      inf         <= inf_nxt;
      done        <= done_nxt;
    end
  end

  // Next-state logic: START outranks STOP, STOP outranks natural completion
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    per_nxt    = per;
    div_nxt    = div_cnt;
    shifts_nxt = shifts;
    sample_nxt = sample;
    full_nxt   = sample_full;
    inf_nxt    = inf;
    done_nxt   = 1'b0;

    if (start) begin
      case (mode_e'(local_cmd[1:0]))
        MODE_CONST: state_nxt = ST_CONST;
        MODE_PWM: begin
          state_nxt = ST_HIGH;
          cnt_nxt   = load_val(duty);
          per_nxt   = load_val(cycles);
          inf_nxt   = local_cmd[2];
        end
        MODE_SAMPLE: begin
          state_nxt  = ST_SAMPLE;
          div_nxt    = sample_div;
          shifts_nxt = '0;
          sample_nxt = '0;
          full_nxt   = 1'b0;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (stop) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_HIGH: begin
          if (cnt == '0) begin
            state_nxt = ST_LOW;
            cnt_nxt   = load_val(anti);
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        ST_LOW: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
          end else if (per == '0 && !inf) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_HIGH;
            cnt_nxt   = load_val(duty);
            if (!inf) per_nxt = per - 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (div_cnt == '0) begin
            div_nxt    = sample_div;
            sample_nxt = {sample[DATA_WIDTH-2:0], pin_s};
            if (!sample_full) begin
              if (shifts == SHW'(DATA_WIDTH - 1)) full_nxt = 1'b1;
              else                                shifts_nxt = shifts + 1'b1;
            end
          end else begin
            div_nxt = div_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pin drive decoded from the current state
  always_comb begin
    pin_oe  = 1'b0;
    pin_out = 1'b0;
    busy    = (state != ST_IDLE);
    case (state)
      ST_CONST: begin
        pin_oe  = 1'b1;
        pin_out = local_cmd[3];
      end
      ST_HIGH: begin
        pin_oe  = 1'b1;
        pin_out = 1'b1;
      end
      ST_LOW: pin_oe = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pin_sequencer.sv
// Scoreboard bench for pin_sequencer at base address 8.
module tb_pin_sequencer;

  localparam int unsigned POS = 8;
  localparam int unsigned AW  = 21;
  localparam int unsigned DW  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic          we;
  logic [DW-1:0] data_out;
  logic          pin_in;
  logic          pin_out, pin_oe, busy, done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int done_base;

  logic [1:0]  pin_q[$];   // expected {pin_oe, pin_out} per clock
  logic [15:0] rd_q[$];    // expected read data
  logic [15:0] rv;

  pin_sequencer #(
    .POSITION   (POS),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .data_in  (data_in),
    .we       (we),
    .data_out (data_out),
    .pin_in   (pin_in),
    .pin_out  (pin_out),
    .pin_oe   (pin_oe),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end just after a falling edge
  task automatic bus_write(input int unsigned a, input logic [15:0] d);
    addr = AW'(a); data_in = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0; addr = '0; data_in = '0;
  endtask

  task automatic read_check(input string tag, input int unsigned a, input logic [15:0] exp);
    rd_q.push_back(exp);
    addr = AW'(a); we = 1'b0;
    @(negedge clk);
    check(tag, data_out, rd_q.pop_front());
    addr = '0;
  endtask

  // Reference PWM waveform: max(d,1) high, max(a,1) low, max(c,1) periods
  task automatic push_pwm(input int d, input int a, input int c, input int periods_override);
    int hi, lo, np;
    hi = (d == 0) ? 1 : d;
    lo = (a == 0) ? 1 : a;
    np = (periods_override > 0) ? periods_override : ((c == 0) ? 1 : c);
    for (int p = 0; p < np; p++) begin
      for (int i = 0; i < hi; i++) pin_q.push_back(2'b11);
      for (int i = 0; i < lo; i++) pin_q.push_back(2'b10);
    end
  endtask

  task automatic check_train(input string tag);
    while (pin_q.size() > 0) begin
      check(tag, {pin_oe, pin_out}, pin_q.pop_front());
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; addr = '0; data_in = '0; we = 1'b0; pin_in = 1'b0;
    @(negedge clk);
    check("rst_outs", {pin_out, pin_oe, busy, done}, 4'b0000);
    check("rst_dout", data_out, 16'h0);
    reset = 1'b1;
    @(negedge clk);

    // Register map
    bus_write(POS + 2, 16'h1234);
    bus_write(POS + 3, 16'h00A5);
    bus_write(POS + 4, 16'h0FF0);
    bus_write(POS + 5, 16'h7777);
    bus_write(POS + 1, 16'h000D);
    bus_write(16 + 2, 16'hBEEF);
    bus_write(POS + 6, 16'hFFFF);
    bus_write(POS + 7, 16'hFFFF);
    bus_write(0, 16'h0003);
    read_check("rd_duty", POS + 2, 16'h1234);
    read_check("rd_anti", POS + 3, 16'h00A5);
    read_check("rd_cyc",  POS + 4, 16'h0FF0);
    read_check("rd_sdiv", POS + 5, 16'h7777);
    read_check("rd_lcmd", POS + 1, 16'h000D);
    read_check("rd_samp_ro", POS + 6, 16'h0000);
    read_check("rd_stat_ro", POS + 7, 16'h0000);
    read_check("rd_addr0", 0, 16'h0000);
    read_check("rd_unmap", POS + 9, 16'h0000);
    check("noop_busy", busy, 1'b0);

    // Finite PWM 3/2/2
    bus_write(POS + 2, 3);
    bus_write(POS + 3, 2);
    bus_write(POS + 4, 2);
    bus_write(POS + 1, 2);
    push_pwm(3, 2, 2, 0);
    done_base = done_cnt;
    bus_write(0, 1);
    check_train("pwm322");
    check("pwm_end", {busy, pin_oe, done}, 3'b001);
    @(negedge clk);
    check("pwm_done_1clk", done, 1'b0);
    check("pwm_done_cnt", done_cnt - done_base, 1);

    // Zero-valued registers: single 1,0 period
    bus_write(POS + 2, 0);
    bus_write(POS + 3, 0);
    bus_write(POS + 4, 0);
    push_pwm(0, 0, 0, 0);
    bus_write(0, 1);
    check_train("pwm000");
    check("pwm0_end", {busy, done}, 2'b01);
    @(negedge clk);

    // Infinite PWM stopped by STOP
    bus_write(POS + 2, 1);
    bus_write(POS + 3, 1);
    bus_write(POS + 1, 6);
    push_pwm(1, 1, 0, 60);
    done_base = done_cnt;
    bus_write(0, 1);
    check_train("pwm_inf");
    bus_write(0, 2);
    check("inf_stop", {busy, pin_oe}, 2'b00);
    @(negedge clk);
    check("inf_no_done", done_cnt - done_base, 0);

    // Constant level, live level change, STOP
    bus_write(POS + 1, 9);
    bus_write(0, 1);
    check("const_hi", {pin_oe, pin_out}, 2'b11);
    bus_write(POS + 1, 1);
    check("const_lo", {pin_oe, pin_out}, 2'b10);
    bus_write(0, 2);
    check("const_stop", {busy, pin_oe}, 2'b00);

    // Sampling an input toggling every 2 clocks, one sample per 2 clocks
    bus_write(POS + 5, 1);
    bus_write(POS + 1, 3);
    bus_write(0, 1);
    for (int i = 0; i < 40; i++) begin
      check("samp_oe", pin_oe, 1'b0);
      if (i % 2 == 1) pin_in = ~pin_in;
      @(negedge clk);
    end
    bus_write(0, 2);
    addr = AW'(POS + 6);
    @(negedge clk);
    rv = data_out;
    check("samp_pat", (rv == 16'h5555) || (rv == 16'hAAAA), 1'b1);
    read_check("samp_status", POS + 7, 16'h0002);

    // Asynchronous reset during HIGH
    bus_write(POS + 2, 5);
    bus_write(POS + 1, 2);
    bus_write(0, 1);
    check("prerst_high", {busy, pin_oe, pin_out}, 3'b111);
    #2 reset = 1'b0;
    #1 check("async_rst", {busy, pin_oe, pin_out}, 3'b000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    read_check("rst_duty", POS + 2, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
